// File: rtl/extrinsic_exchange.sv
// Extrinsic exchange stage between two SISO decoders.
// Captures a finished block, computes scaled extrinsics one element per cycle,
// permutes them for the next SISO and hands them over with read_en/ready.
// On the last half-iteration it emits hard decisions instead of extrinsics.
module extrinsic_exchange #(
    parameter int DATA_SIZE     = 10,
    parameter int EXTEND_SIZE   = 7,
    parameter int MAX_HALF_ITER = 8
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            finish_i,
    input  logic [DATA_SIZE*EXTEND_SIZE-1:0] llr_i,
    input  logic [4*EXTEND_SIZE-1:0]         sys_i,
    input  logic [DATA_SIZE*EXTEND_SIZE-1:0] ext_i,
    output logic [DATA_SIZE*EXTEND_SIZE-1:0] ext_o,
    output logic                            read_en_o,
    input  logic                            ready_i,
    output logic [EXTEND_SIZE-1:0]           bits_o,
    output logic                            bits_valid_o,
    output logic [3:0]                      half_iter_o,
    output logic                            overrun_o
);
    localparam int W      = DATA_SIZE * EXTEND_SIZE;
    localparam int SW     = 4 * EXTEND_SIZE;
    localparam int CW     = DATA_SIZE + 2;
    localparam int IDX_W  = $clog2(EXTEND_SIZE);
    localparam int P_EVEN = 3;
    localparam int P_ODD  = 5;

    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, OUTPUT = 2'd2} state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [W-1:0]                  llr_q, llr_d;
    logic [SW-1:0]                 sys_q, sys_d;
    logic [W-1:0]                  exti_q, exti_d;
    logic signed [DATA_SIZE-1:0]   e_q [EXTEND_SIZE];
    logic signed [DATA_SIZE-1:0]   e_d [EXTEND_SIZE];
    logic [W-1:0]                  ext_q, ext_d;
    logic                          read_en_q, read_en_d;
    logic [EXTEND_SIZE-1:0]        bits_q, bits_d;
    logic                          bits_valid_q, bits_valid_d;
    logic [3:0]                    half_q, half_d;
    logic                          overrun_q, overrun_d;

    logic signed [DATA_SIZE-1:0]   llr_k_s, ext_k_s, e_cur_s;
    logic signed [3:0]             sys_k_s;
    logic signed [CW-1:0]          d_s, s_s;

    // Saturate a CW-bit signed value into the DATA_SIZE-bit signed range.
    function automatic logic signed [DATA_SIZE-1:0] sat(input logic signed [CW-1:0] v);
        logic signed [CW-1:0] hi;
        logic signed [CW-1:0] lo;
        hi = CW'((2 ** (DATA_SIZE - 1)) - 1);
        lo = -hi - CW'(1);
        if (v > hi) begin
            sat = hi[DATA_SIZE-1:0];
        end else if (v < lo) begin
            sat = lo[DATA_SIZE-1:0];
        end else begin
            sat = v[DATA_SIZE-1:0];
        end
    endfunction

    // Strictly positive test for a signed LLR (zero decides to 0).
    function automatic logic is_pos(input logic [DATA_SIZE-1:0] v);
        is_pos = !v[DATA_SIZE-1] && (v != {DATA_SIZE{1'b0}});
    endfunction

    // Extrinsic of the element currently addressed by idx.
    always_comb begin
        llr_k_s = llr_q[W-1-DATA_SIZE*int'(idx_q) -: DATA_SIZE];
        ext_k_s = exti_q[W-1-DATA_SIZE*int'(idx_q) -: DATA_SIZE];
        sys_k_s = sys_q[SW-1-4*int'(idx_q) -: 4];
        d_s     = CW'(llr_k_s) - CW'(sys_k_s) - CW'(ext_k_s);
        s_s     = d_s - (d_s >>> 2);
        e_cur_s = sat(s_s);
    end

    // Next-state, capture, permutation and handshake logic.
    always_comb begin
        int src;
        int mult;
        state_d      = state_q;
        idx_d        = idx_q;
        llr_d        = llr_q;
        sys_d        = sys_q;
        exti_d       = exti_q;
        e_d          = e_q;
        ext_d        = ext_q;
        read_en_d    = read_en_q;
        bits_d       = bits_q;
        bits_valid_d = 1'b0;
        half_d       = half_q;
        overrun_d    = overrun_q;
        mult         = half_q[0] ? P_ODD : P_EVEN;
        src          = 0;
        case (state_q)
            IDLE: begin
                if (finish_i) begin
                    llr_d   = llr_i;
                    sys_d   = sys_i;
                    exti_d  = ext_i;
                    idx_d   = {IDX_W{1'b0}};
                    state_d = COMPUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPUTE: begin
                e_d[idx_q] = e_cur_s;
                if (idx_q == IDX_W'(EXTEND_SIZE - 1)) begin
                    if (half_q == 4'(MAX_HALF_ITER - 1)) begin
                        for (int j = 0; j < EXTEND_SIZE; j++) begin
                            src = (mult * j) % EXTEND_SIZE;
                            bits_d[EXTEND_SIZE-1-j] = is_pos(llr_q[W-1-DATA_SIZE*src -: DATA_SIZE]);
                        end
                        bits_valid_d = 1'b1;
                        half_d       = 4'd0;
                        state_d      = IDLE;
                    end else begin
                        for (int j = 0; j < EXTEND_SIZE; j++) begin
                            src = (mult * j) % EXTEND_SIZE;
                            ext_d[W-1-DATA_SIZE*j -: DATA_SIZE] = e_d[src];
                        end
                        read_en_d = 1'b1;
                        state_d   = OUTPUT;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            OUTPUT: begin
                if (ready_i) begin
                    read_en_d = 1'b0;
                    half_d    = half_q + 4'd1;
                    state_d   = IDLE;
                end else begin
                    read_en_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (finish_i && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_d;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            idx_q        <= {IDX_W{1'b0}};
            llr_q        <= {W{1'b0}};
            sys_q        <= {SW{1'b0}};
            exti_q       <= {W{1'b0}};
            for (int k = 0; k < EXTEND_SIZE; k++) begin
                e_q[k] <= {DATA_SIZE{1'b0}};
            end
            ext_q        <= {W{1'b0}};
            read_en_q    <= 1'b0;
            bits_q       <= {EXTEND_SIZE{1'b0}};
            bits_valid_q <= 1'b0;
            half_q       <= 4'd0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            llr_q        <= llr_d;
            sys_q        <= sys_d;
            exti_q       <= exti_d;
            e_q          <= e_d;
            ext_q        <= ext_d;
            read_en_q    <= read_en_d;
            bits_q       <= bits_d;
            bits_valid_q <= bits_valid_d;
            half_q       <= half_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ext_o        = ext_q;
    assign read_en_o    = read_en_q;
    assign bits_o       = bits_q;
    assign bits_valid_o = bits_valid_q;
    assign half_iter_o  = half_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_extrinsic_exchange.sv
// Directed/random bench for extrinsic_exchange against a rule-level model.
module tb_extrinsic_exchange;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        finish_i;
    logic [69:0] llr_i;
    logic [27:0] sys_i;
    logic [69:0] ext_i;
    logic [69:0] ext_o;
    logic        read_en_o;
    logic        ready_i;
    logic [6:0]  bits_o;
    logic        bits_valid_o;
    logic [3:0]  half_iter_o;
    logic        overrun_o;

    int tests = 0;
    int fails = 0;
    int model_half = 0;
    int handshakes = 0;

    extrinsic_exchange #(.DATA_SIZE(10), .EXTEND_SIZE(7), .MAX_HALF_ITER(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .finish_i(finish_i),
        .llr_i(llr_i), .sys_i(sys_i), .ext_i(ext_i),
        .ext_o(ext_o), .read_en_o(read_en_o), .ready_i(ready_i),
        .bits_o(bits_o), .bits_valid_o(bits_valid_o),
        .half_iter_o(half_iter_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic straight from the rules (floor division, clamp, index maps).
    function automatic void model(input int llr[7], input int sys[7], input int ext[7],
                                  input int half, output logic [69:0] eo, output logic [6:0] bo);
        int e[7];
        int d, q, s, src;
        for (int k = 0; k < 7; k++) begin
            d = llr[k] - sys[k] - ext[k];
            q = (d >= 0) ? d / 4 : -((-d + 3) / 4);
            s = d - q;
            e[k] = (s > 511) ? 511 : ((s < -512) ? -512 : s);
        end
        for (int j = 0; j < 7; j++) begin
            src = (((half % 2) == 1) ? 5 * j : 3 * j) % 7;
            eo[69-10*j -: 10] = 10'(e[src]);
            bo[6-j] = (llr[src] > 0);
        end
    endfunction

    task automatic drive(input int llr[7], input int sys[7], input int ext[7]);
        for (int j = 0; j < 7; j++) begin
            llr_i[69-10*j -: 10] = 10'(llr[j]);
            ext_i[69-10*j -: 10] = 10'(ext[j]);
            sys_i[27-4*j -: 4]   = 4'(sys[j]);
        end
    endtask

    // One half-iteration: capture, latency check, result check, optional stall.
    task automatic run_half(input int llr[7], input int sys[7], input int ext[7],
                            input int stall, input bit rdy_early, input bit pulse_fin);
        logic [69:0] exp_ext;
        logic [6:0]  exp_bits;
        model(llr, sys, ext, model_half, exp_ext, exp_bits);
        @(negedge clk_i);
        drive(llr, sys, ext);
        finish_i = 1'b1;
        ready_i  = rdy_early;
        @(negedge clk_i);
        finish_i = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk_i);
            if (n == 6) begin
                chk("read_en_before_latency", {69'd0, read_en_o}, 70'd0);
            end
        end
        if (model_half == 7) begin
            chk("bits_valid_pulse", {69'd0, bits_valid_o}, 70'd1);
            chk("bits_o", {63'd0, bits_o}, {63'd0, exp_bits});
            chk("final_read_en", {69'd0, read_en_o}, 70'd0);
            chk("final_half_wrap", {66'd0, half_iter_o}, 70'd0);
            @(negedge clk_i);
            chk("bits_valid_drop", {69'd0, bits_valid_o}, 70'd0);
            chk("bits_hold", {63'd0, bits_o}, {63'd0, exp_bits});
            chk("final_no_read_en", {69'd0, read_en_o}, 70'd0);
            ready_i    = 1'b0;
            model_half = 0;
        end else begin
            chk("read_en_latency", {69'd0, read_en_o}, 70'd1);
            chk("ext_o", ext_o, exp_ext);
            chk("half_iter", {66'd0, half_iter_o}, 70'(model_half));
            if (read_en_o === 1'b1) handshakes++;
            for (int s = 0; s < stall; s++) begin
                if (pulse_fin && s == 1) finish_i = 1'b1;
                @(negedge clk_i);
                finish_i = 1'b0;
                chk("stall_read_en", {69'd0, read_en_o}, 70'd1);
                chk("stall_ext_stable", ext_o, exp_ext);
            end
            ready_i = 1'b1;
            @(negedge clk_i);
            ready_i = 1'b0;
            model_half++;
            chk("handshake_read_en_drop", {69'd0, read_en_o}, 70'd0);
            chk("handshake_half_inc", {66'd0, half_iter_o}, 70'(model_half));
        end
    endtask

    int a_llr[7];
    int a_sys[7];
    int a_ext[7];
    bit seen_bad;

    initial begin
        reset_i  = 1'b1;
        finish_i = 1'b0;
        ready_i  = 1'b0;
        llr_i    = '0;
        sys_i    = '0;
        ext_i    = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_ext_o", ext_o, 70'd0);
        chk("reset_flags", {62'd0, read_en_o, bits_valid_o, overrun_o, bits_o[0], half_iter_o},
            70'd0);
        reset_i = 1'b0;

        // Half 0: uniform block, every element 100-4-20=76 -> 57.
        foreach (a_llr[k]) begin a_llr[k] = 100; a_sys[k] = 4; a_ext[k] = 20; end
        run_half(a_llr, a_sys, a_ext, 0, 1'b0, 1'b0);
        chk("basic_const", ext_o, {7{10'd57}});
        chk("overrun_clear", {69'd0, overrun_o}, 70'd0);

        // Half 1: ramp exposes the odd-half permutation.
        foreach (a_llr[k]) begin a_llr[k] = 10 * k; a_sys[k] = 0; a_ext[k] = 0; end
        run_half(a_llr, a_sys, a_ext, 0, 1'b0, 1'b0);

        // Half 2: alternating positive/negative saturation.
        foreach (a_llr[k]) begin
            a_llr[k] = (k % 2 == 0) ? 511 : -512;
            a_sys[k] = (k % 2 == 0) ? -8 : 7;
            a_ext[k] = (k % 2 == 0) ? -512 : 511;
        end
        run_half(a_llr, a_sys, a_ext, 0, 1'b0, 1'b0);

        // Half 3: 5-cycle stall with a stray finish pulse.
        foreach (a_llr[k]) begin
            a_llr[k] = int'($urandom_range(1023)) - 512;
            a_sys[k] = int'($urandom_range(15)) - 8;
            a_ext[k] = int'($urandom_range(1023)) - 512;
        end
        run_half(a_llr, a_sys, a_ext, 5, 1'b0, 1'b1);
        chk("overrun_set", {69'd0, overrun_o}, 70'd1);

        // Halves 4..6 random; half 4 holds ready high while computing.
        for (int h = 4; h <= 6; h++) begin
            foreach (a_llr[k]) begin
                a_llr[k] = int'($urandom_range(1023)) - 512;
                a_sys[k] = int'($urandom_range(15)) - 8;
                a_ext[k] = int'($urandom_range(1023)) - 512;
            end
            run_half(a_llr, a_sys, a_ext, int'($urandom_range(2)) * ((h == 4) ? 0 : 1),
                     (h == 4), 1'b0);
        end

        // Half 7: final decisions.
        foreach (a_llr[k]) begin a_llr[k] = 10 * k - 30; a_sys[k] = 0; a_ext[k] = 0; end
        run_half(a_llr, a_sys, a_ext, 0, 1'b0, 1'b0);
        chk("frame_handshakes", 70'(handshakes), 70'd7);
        chk("overrun_sticky", {69'd0, overrun_o}, 70'd1);

        // Reset 3 cycles into half 1.
        foreach (a_llr[k]) begin a_llr[k] = 100; a_sys[k] = 4; a_ext[k] = 20; end
        run_half(a_llr, a_sys, a_ext, 0, 1'b0, 1'b0);
        @(negedge clk_i);
        drive(a_llr, a_sys, a_ext);
        finish_i = 1'b1;
        @(negedge clk_i);
        finish_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        chk("rst_ext_o", ext_o, 70'd0);
        chk("rst_outputs", {57'd0, read_en_o, bits_valid_o, overrun_o, bits_o, half_iter_o}, 70'd0);
        @(negedge clk_i);
        reset_i  = 1'b0;
        seen_bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (read_en_o !== 1'b0 || bits_valid_o !== 1'b0) seen_bad = 1'b1;
        end
        chk("no_output_after_reset", {69'd0, seen_bad}, 70'd0);
        model_half = 0;
        run_half(a_llr, a_sys, a_ext, 0, 1'b0, 1'b0);
        chk("post_reset_basic", ext_o, {7{10'd57}});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
